// File: rtl/mux_16to1.sv
// rtl/mux_16to1.sv - registered 16-to-1 multiplexer with valid flag
// Optional MUX_16TO1_PARITY_EN adds registered even parity output out_parity.
module mux_16to1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [WIDTH-1:0] d4,
   input  logic [WIDTH-1:0] d5,
   input  logic [WIDTH-1:0] d6,
   input  logic [WIDTH-1:0] d7,
   input  logic [WIDTH-1:0] d8,
   input  logic [WIDTH-1:0] d9,
   input  logic [WIDTH-1:0] d10,
   input  logic [WIDTH-1:0] d11,
   input  logic [WIDTH-1:0] d12,
   input  logic [WIDTH-1:0] d13,
   input  logic [WIDTH-1:0] d14,
   input  logic [WIDTH-1:0] d15,
   input  logic [3:0]       sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
`ifdef MUX_16TO1_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   logic [WIDTH-1:0] sel_data;

   always_comb begin
      sel_data = d0;
      case (sel)
         4'd0:  sel_data = d0;
         4'd1:  sel_data = d1;
         4'd2:  sel_data = d2;
         4'd3:  sel_data = d3;
         4'd4:  sel_data = d4;
         4'd5:  sel_data = d5;
         4'd6:  sel_data = d6;
         4'd7:  sel_data = d7;
         4'd8:  sel_data = d8;
         4'd9:  sel_data = d9;
         4'd10: sel_data = d10;
         4'd11: sel_data = d11;
         4'd12: sel_data = d12;
         4'd13: sel_data = d13;
         4'd14: sel_data = d14;
         4'd15: sel_data = d15;
         default: sel_data = d0;
      endcase
   end

   // Data holds when idle; only the valid flag drops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out <= sel_data;
         end
      end
   end

`ifdef MUX_16TO1_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_parity <= 1'b0;
      end else if (in_valid) begin
         out_parity <= ^sel_data;
      end
   end
`endif

endmodule

// File: tb/tb_mux_16to1.sv
// tb/tb_mux_16to1.sv - scoreboard bench for mux_16to1
// Builds WIDTH=8 with parity checks when MUX_16TO1_PARITY_EN is defined.
module tb_mux_16to1;

`ifdef MUX_16TO1_PARITY_EN
   localparam int W = 8;
`else
   localparam int W = 1;
`endif

   typedef struct {
      logic         v;
      logic [W-1:0] o;
      logic         p;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   sel = '0;
   logic         in_valid = 1'b0;
   logic [W-1:0] d [16];
   logic [W-1:0] out;
   logic         out_valid;
`ifdef MUX_16TO1_PARITY_EN
   logic         out_parity;
`endif

   exp_t         exp_q[$];
   logic [W-1:0] m_out = '0;
   logic         m_par = 1'b0;
   int           n_vec = 0;
   int           n_err = 0;
   bit           done = 1'b0;

   always #5 clk = ~clk;

   mux_16to1 #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
      .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
      .d8(d[8]), .d9(d[9]), .d10(d[10]), .d11(d[11]),
      .d12(d[12]), .d13(d[13]), .d14(d[14]), .d15(d[15]),
      .sel(sel), .in_valid(in_valid),
      .out(out), .out_valid(out_valid)
`ifdef MUX_16TO1_PARITY_EN
      , .out_parity(out_parity)
`endif
   );

   // Reference: output register is "last word picked while valid", cleared by reset.
   task automatic drive(input logic r, input logic v, input logic [3:0] s,
                        input logic [16*W-1:0] dv);
      exp_t e;
      @(negedge clk);
      rst_n = r; in_valid = v; sel = s;
      for (int i = 0; i < 16; i++) d[i] = dv[i*W +: W];
      if (!r) begin
         m_out = '0; m_par = 1'b0;
      end else if (v) begin
         m_out = dv[s*W +: W];
         m_par = 1'b0;
         for (int b = 0; b < W; b++) m_par = m_par ^ m_out[b];
      end
      e.v = r & v; e.o = m_out; e.p = m_par;
      exp_q.push_back(e);
   endtask

   function automatic logic [16*W-1:0] bits_to_words(input logic [15:0] bits);
      logic [16*W-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[i*W] = bits[i];
      return r;
   endfunction

   function automatic logic [16*W-1:0] rand_words();
      logic [16*W-1:0] r;
      for (int i = 0; i < 16; i++) r[i*W +: W] = W'($urandom);
      return r;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (out_valid !== e.v) begin
               n_err++;
               $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, e.v);
            end
            if (out !== e.o) begin
               n_err++;
               $display("FAIL out t=%0t got=%h exp=%h", $time, out, e.o);
            end
`ifdef MUX_16TO1_PARITY_EN
            if (out_parity !== e.p) begin
               n_err++;
               $display("FAIL out_parity t=%0t got=%b exp=%b", $time, out_parity, e.p);
            end
`endif
         end
      end
   end

   initial begin : watchdog
      #500000;
      if (!done) begin
         $display("FAIL watchdog timeout at t=%0t", $time);
         $fatal(1, "watchdog");
      end
   end

   initial begin : stimulus
      logic [16*W-1:0] dv;
      logic [3:0] s;
      for (int i = 0; i < 16; i++) d[i] = '0;

      // Reset held with valid input asserted
      drive(1'b0, 1'b1, 4'd3, rand_words());
      drive(1'b0, 1'b1, 4'd7, rand_words());

      // Basic selection on 16'h023A
      dv = bits_to_words(16'h023A);
      drive(1'b1, 1'b1, 4'd0, dv);
      drive(1'b1, 1'b1, 4'd4, dv);
      drive(1'b1, 1'b1, 4'd15, dv);
      drive(1'b1, 1'b1, 4'd1, dv);
      drive(1'b1, 1'b1, 4'd9, dv);

      // Walking one across every select code
      for (int k = 0; k < 16; k++) begin
         for (int j = 0; j < 16; j++) begin
            dv = '0;
            dv[k*W] = 1'b1;
            drive(1'b1, 1'b1, 4'(j), dv);
         end
      end

      // Hold: capture then idle with changed inputs
      drive(1'b1, 1'b1, 4'd4, bits_to_words(16'h023A));
      drive(1'b1, 1'b0, 4'd0, '0);
      drive(1'b1, 1'b0, 4'd0, '0);

      // Reset on the same edge as a valid selection, then resume
      dv = bits_to_words(16'h0020);
      drive(1'b0, 1'b1, 4'd5, dv);
      drive(1'b1, 1'b1, 4'd5, dv);
      drive(1'b1, 1'b0, 4'd5, dv);

`ifdef MUX_16TO1_PARITY_EN
      dv = '0;
      dv[3*W +: W] = 8'hB5;
      drive(1'b1, 1'b1, 4'd3, dv);
      dv[3*W +: W] = 8'h33;
      drive(1'b1, 1'b1, 4'd3, dv);
`endif

      // Random traffic with occasional reset
      for (int n = 0; n < 300; n++) begin
         s = 4'($urandom_range(0, 15));
         drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), s, rand_words());
      end

      drive(1'b1, 1'b0, 4'd0, '0);
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux_16to1.md
Name: mux_16to1

Overview:
- Registered 16-to-1 multiplexer. Selects one of sixteen data inputs with a 4-bit select and presents it on a registered output.
- One-cycle latency, with a valid flag travelling alongside the data.
- Used as a generic selection leaf inside datapath and config-readback logic.

Parameters:
- WIDTH, 1, bit width of each data input and of the output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- d0 .. d15  input  WIDTH each  data inputs; dN is selected when sel == N.
- sel  input  4  select index, unsigned, 0..15.
- in_valid  input  1  qualifies d0..d15 and sel this cycle.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  high when out holds a result captured from an in_valid cycle.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset: on a rising clk edge with rst_n == 0, out <= 0 and out_valid <= 0. Reset has priority over in_valid.
  - Reset mid-stream discards the pending result.
  - First valid output is 1 cycle after the first in_valid sampled with rst_n == 1.
- Selection: combinational choice sel_data = d[sel]. Index order is d0 = index 0 through d15 = index 15, with no bit reversal. All 16 codes are legal, so there is no out-of-range case.
- Capture, on each rising edge with rst_n == 1:
  - in_valid == 1: out <= sel_data and out_valid <= 1.
  - in_valid == 0: out holds its previous value and out_valid <= 0.
- Latency: exactly 1 clock from the sampled (in_valid, sel, dN) to out and out_valid.
- Throughput: one selection per cycle. Back-to-back in_valid cycles with different sel values produce back-to-back outputs in order.
- No backpressure: there is no ready signal, and the consumer must accept out whenever out_valid is high.
- Changes to sel or dN between clock edges have no effect. Only the values at the edge matter.
- Width rules: the output is exactly WIDTH bits with no extension or truncation. Multi-bit inputs are selected as whole words.

Optional Feature:
- Macro MUX_16TO1_PARITY_EN.
- When defined:
  - Adds output port out_parity (1 bit): the registered even parity (XOR reduction) of the selected data word.
  - Captured on the same edge and under the same in_valid and hold rules as out.
  - Reset value is 0.
- When not defined: the port does not exist, and the logic and timing of out and out_valid are identical.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 and arbitrary data -> out == 0 and out_valid == 0 throughout. The first in_valid after release gives out_valid == 1 one cycle later.
- Basic selection, WIDTH = 1, data word {d15..d0} = 16'h023A with in_valid = 1:
  - sel = 0 -> out == 0 next cycle.
  - sel = 4 -> out == 1.
  - sel = 15 -> out == 0.
  - sel = 1 -> out == 1.
  - sel = 9 -> out == 1.
- Exhaustive sweep: drive dN with a walking-one pattern (only d[k] = 1) for each k = 0..15 and each sel = 0..15 -> out == 1 only when sel == k; otherwise 0, each exactly 1 cycle after drive.
- Hold and valid: capture sel = 4 (out = 1), then set in_valid = 0 and change sel to 0 and all data to 0 -> out stays 1 and out_valid drops to 0 on the next cycle.
- Mid-operation reset: in_valid = 1 with sel = 5 (d5 = 1) on the same edge that rst_n = 0 -> out == 0 and out_valid == 0. The next valid cycle resumes with normal 1-cycle latency.
- With MUX_16TO1_PARITY_EN and WIDTH = 8: d3 = 8'hB5, sel = 3 -> out == 8'hB5 and out_parity == 1. d3 = 8'h33 -> out_parity == 0.
